// File: rtl/d_ip_timer_arb.sv
// d_ip_timer_arb: two-requester arbiter in front of a single timer register port.
// One transaction is outstanding at a time: IDLE samples and latches the winner,
// ACCESS drives the timer bus for one cycle, and RDWAIT waits RD_LAT cycles for read data.
// Optional build macro D_IP_TIMER_ARB_FIXED_PRIO_EN selects fixed priority (r0 over r1)
// instead of round-robin arbitration.
module d_ip_timer_arb #(
    parameter int RD_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       r0_req,
    input  logic       r0_wr,
    input  logic [5:0] r0_addr,
    input  logic [7:0] r0_wdata,
    output logic       r0_gnt,
    output logic       r0_rvalid,
    output logic [7:0] r0_rdata,
    input  logic       r1_req,
    input  logic       r1_wr,
    input  logic [5:0] r1_addr,
    input  logic [7:0] r1_wdata,
    output logic       r1_gnt,
    output logic       r1_rvalid,
    output logic [7:0] r1_rdata,
    output logic [5:0] tm_addr,
    output logic [7:0] tm_wdata,
    output logic       tm_wr_en,
    output logic       tm_mod_en,
    input  logic [7:0] tm_rdata,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDWAIT = 2'd2
    } state_t;

    // Index of the final RDWAIT cycle; tm_rdata is captured at its end.
    localparam logic [1:0] LAST_CNT = 2'(RD_LAT - 1);

    state_t     state_q, state_d;
    logic       owner_q, owner_d;
    logic       wr_q, wr_d;
    logic [5:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [1:0] cnt_q, cnt_d;
    logic [7:0] r0_rdata_q, r0_rdata_d;
    logic [7:0] r1_rdata_q, r1_rdata_d;
    logic       r0_rvalid_q, r0_rvalid_d;
    logic       r1_rvalid_q, r1_rvalid_d;
`ifndef D_IP_TIMER_ARB_FIXED_PRIO_EN
    logic       last_q, last_d;
`endif

    logic       any_req;
    logic       win;
    logic       in_access;

    // Arbitration: pick the requester that wins if the arbiter is sampling this cycle
    always_comb begin
        any_req = r0_req | r1_req;
`ifdef D_IP_TIMER_ARB_FIXED_PRIO_EN
        win = ~r0_req;
`else
        if (r0_req && r1_req) begin
            win = ~last_q;
        end else begin
            win = ~r0_req;
        end
`endif
    end

    // Next-state logic: transaction sequencing, request latching and read-data capture
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        r0_rdata_d  = r0_rdata_q;
        r1_rdata_d  = r1_rdata_q;
        r0_rvalid_d = 1'b0;
        r1_rvalid_d = 1'b0;
`ifndef D_IP_TIMER_ARB_FIXED_PRIO_EN
        last_d      = last_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_d = win;
                    wr_d    = win ? r1_wr    : r0_wr;
                    addr_d  = win ? r1_addr  : r0_addr;
                    wdata_d = win ? r1_wdata : r0_wdata;
`ifndef D_IP_TIMER_ARB_FIXED_PRIO_EN
                    last_d  = win;
`endif
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                cnt_d   = '0;
                state_d = wr_q ? IDLE : RDWAIT;
            end
            RDWAIT: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = IDLE;
                    if (owner_q) begin
                        r1_rdata_d  = tm_rdata;
                        r1_rvalid_d = 1'b1;
                    end else begin
                        r0_rdata_d  = tm_rdata;
                        r0_rvalid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            r0_rdata_q  <= '0;
            r1_rdata_q  <= '0;
            r0_rvalid_q <= 1'b0;
            r1_rvalid_q <= 1'b0;
`ifndef D_IP_TIMER_ARB_FIXED_PRIO_EN
            last_q      <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            r0_rdata_q  <= r0_rdata_d;
            r1_rdata_q  <= r1_rdata_d;
            r0_rvalid_q <= r0_rvalid_d;
            r1_rvalid_q <= r1_rvalid_d;
`ifndef D_IP_TIMER_ARB_FIXED_PRIO_EN
            last_q      <= last_d;
`endif
        end
    end

    // Output decode: the timer bus and grants are live only in ACCESS, zero otherwise
    always_comb begin
        in_access = (state_q == ACCESS);
        tm_mod_en = in_access;
        tm_wr_en  = in_access & wr_q;
        tm_addr   = in_access ? addr_q  : '0;
        tm_wdata  = in_access ? wdata_q : '0;
        r0_gnt    = in_access & ~owner_q;
        r1_gnt    = in_access & owner_q;
        r0_rvalid = r0_rvalid_q;
        r1_rvalid = r1_rvalid_q;
        r0_rdata  = r0_rdata_q;
        r1_rdata  = r1_rdata_q;
        busy      = (state_q != IDLE);
    end

endmodule

// File: tb/tb_d_ip_timer_arb.sv
// Bench for d_ip_timer_arb: two random requester drivers push expected transactions into
// per-requester queues; a negedge monitor pops them on each grant and checks the bus,
// arbitration order, read latency/data, busy and output hold against a reference model.
module tb_d_ip_timer_arb;

    localparam int RD_LAT = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       r0_req, r0_wr, r1_req, r1_wr;
    logic [5:0] r0_addr, r1_addr;
    logic [7:0] r0_wdata, r1_wdata;
    logic       r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
    logic [7:0] r0_rdata, r1_rdata;
    logic [5:0] tm_addr;
    logic [7:0] tm_wdata;
    logic       tm_wr_en, tm_mod_en;
    logic [7:0] tm_rdata;
    logic       busy;

    always #5 clk = ~clk;

    d_ip_timer_arb #(.RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_wr(r0_wr), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_wr(r1_wr), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .tm_addr(tm_addr), .tm_wdata(tm_wdata), .tm_wr_en(tm_wr_en),
        .tm_mod_en(tm_mod_en), .tm_rdata(tm_rdata), .busy(busy)
    );

    typedef struct packed {
        logic       wr;
        logic [5:0] addr;
        logic [7:0] wdata;
    } txn_t;

    txn_t q0[$];
    txn_t q1[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] init_val(input logic [5:0] a);
        return {a, 2'b01} ^ 8'h5A;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Timer model: memory with RD_LAT read pipeline; random noise when no read data is due
    logic [7:0] tmem [64];
    bit         written [64];
    bit         pv [RD_LAT];
    logic [5:0] pa [RD_LAT];
    logic [7:0] noise = 8'h00;

    always @(posedge clk) begin
        noise <= 8'($urandom);
        if (tm_mod_en && tm_wr_en) begin
            tmem[tm_addr]    <= tm_wdata;
            written[tm_addr] <= 1'b1;
        end
        pv[0] <= tm_mod_en && !tm_wr_en;
        pa[0] <= tm_addr;
        for (int i = 1; i < RD_LAT; i++) begin
            pv[i] <= pv[i-1];
            pa[i] <= pa[i-1];
        end
    end

    assign tm_rdata = pv[RD_LAT-1] ?
        (written[pa[RD_LAT-1]] ? tmem[pa[RD_LAT-1]] : init_val(pa[RD_LAT-1])) : noise;

    task automatic set_req(input int r, input logic v, input txn_t t);
        if (r == 0) begin
            r0_req = v; r0_wr = t.wr; r0_addr = t.addr; r0_wdata = t.wdata;
        end else begin
            r1_req = v; r1_wr = t.wr; r1_addr = t.addr; r1_wdata = t.wdata;
        end
    endtask

    task automatic push(input int r, input txn_t t);
        if (r == 0) q0.push_back(t); else q1.push_back(t);
    endtask

    task automatic withdraw(input int r);
        if (r == 0) void'(q0.pop_back()); else void'(q1.pop_back());
    endtask

    function automatic logic gnt_of(input int r);
        return (r == 0) ? r0_gnt : r1_gnt;
    endfunction

    // Random requester: optional gap, random op, wait for grant or withdraw early
    task automatic drive(input int r, input int n);
        txn_t t;
        int   wd;
        int   waited;
        bit   done;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 2) != 0) begin
                repeat ($urandom_range(1, 4)) begin @(posedge clk); #1; end
            end
            t.wr    = 1'($urandom_range(0, 1));
            t.addr  = 6'($urandom);
            t.wdata = 8'($urandom);
            push(r, t);
            set_req(r, 1'b1, t);
            wd     = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 2)) : -1;
            waited = 0;
            done   = 1'b0;
            while (!done) begin
                @(posedge clk); #1;
                if (gnt_of(r)) begin
                    done = 1'b1;
                end else if (waited == wd) begin
                    withdraw(r);
                    done = 1'b1;
                end else if (waited > 60) begin
                    n_vec++; n_err++;
                    $display("FAIL grant_timeout: requester %0d got no gnt expected gnt within 60 cycles", r);
                    withdraw(r);
                    done = 1'b1;
                end
                waited++;
            end
            set_req(r, 1'b0, t);
        end
    endtask

    // Monitor and reference model, sampled on the falling edge
    initial begin
        logic [7:0] ref_mem [64];
        logic [7:0] exp_rd [2];
        int         busy_left;
        int         pend_due;
        bit         pend, pend_own, last, exp_g, exp_w, idle;
        logic [7:0] pend_data;
        logic [1:0] exp_rv;
        txn_t       t;
        for (int a = 0; a < 64; a++) ref_mem[a] = init_val(6'(a));
        exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
        busy_left = 0; pend = 1'b0; pend_own = 1'b0; pend_due = 0; pend_data = 8'h00;
        last = 1'b1; exp_g = 1'b0; exp_w = 1'b0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("gnt", 32'({r1_gnt, r0_gnt}), exp_g ? (exp_w ? 32'd2 : 32'd1) : 32'd0);
            if (exp_g) begin
                if ((exp_w && q1.size() == 0) || (!exp_w && q0.size() == 0)) begin
                    n_vec++; n_err++;
                    $display("FAIL scoreboard: got grant for requester %0d expected no pending request", exp_w);
                end else begin
                    t = exp_w ? q1.pop_front() : q0.pop_front();
                    check("tm_mod_en", 32'(tm_mod_en), 32'd1);
                    check("tm_wr_en", 32'(tm_wr_en), 32'(t.wr));
                    check("tm_addr", 32'(tm_addr), 32'(t.addr));
                    check("tm_wdata", 32'(tm_wdata), 32'(t.wdata));
                    last = exp_w;
                    if (t.wr) begin
                        ref_mem[t.addr] = t.wdata;
                        busy_left = 1;
                    end else begin
                        busy_left = RD_LAT + 1;
                        pend      = 1'b1;
                        pend_own  = exp_w;
                        pend_due  = cyc + RD_LAT + 1;
                        pend_data = ref_mem[t.addr];
                    end
                end
            end else begin
                check("tm_idle", 32'({tm_mod_en, tm_wr_en, tm_addr, tm_wdata}), 32'd0);
            end
            exp_rv = (pend && pend_due == cyc) ? (pend_own ? 2'b10 : 2'b01) : 2'b00;
            check("rvalid", 32'({r1_rvalid, r0_rvalid}), 32'(exp_rv));
            if (exp_rv != 2'b00) begin
                exp_rd[pend_own] = pend_data;
                pend = 1'b0;
            end
            check("r0_rdata", 32'(r0_rdata), 32'(exp_rd[0]));
            check("r1_rdata", 32'(r1_rdata), 32'(exp_rd[1]));
            check("busy", 32'(busy), 32'(busy_left > 0));
            idle = (busy_left == 0);
            if (busy_left > 0) busy_left--;
            exp_g = idle && (r0_req || r1_req) && !rst;
`ifdef D_IP_TIMER_ARB_FIXED_PRIO_EN
            exp_w = !r0_req;
`else
            exp_w = (r0_req && r1_req) ? !last : !r0_req;
`endif
            if (rst) begin
                busy_left = 0; pend = 1'b0; last = 1'b1; exp_g = 1'b0;
                exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        txn_t ta, tb;
        bit   g0, g1, first;
        rst = 1'b1;
        ta = '0;
        set_req(0, 1'b0, ta);
        set_req(1, 1'b0, ta);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        fork
            drive(0, 150);
            drive(1, 150);
        join
        repeat (10) begin @(posedge clk); #1; end

        // Reset in the first RDWAIT cycle of an r0 read
        ta = '{wr: 1'b0, addr: 6'h10, wdata: 8'h00};
        push(0, ta);
        set_req(0, 1'b1, ta);
        g0 = 1'b0;
        for (int i = 0; i < 10 && !g0; i++) begin
            @(posedge clk); #1;
            g0 = r0_gnt;
        end
        check("mid_read_gnt", 32'(g0), 32'd1);
        if (!g0) withdraw(0);
        set_req(0, 1'b0, ta);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (RD_LAT + 3) begin @(posedge clk); #1; end

        // Tie after reset: r0 must win first
        ta = '{wr: 1'b1, addr: 6'h05, wdata: 8'hA5};
        tb = '{wr: 1'b1, addr: 6'h2A, wdata: 8'h3C};
        push(0, ta); push(1, tb);
        set_req(0, 1'b1, ta); set_req(1, 1'b1, tb);
        g0 = 1'b0; g1 = 1'b0; first = 1'b1;
        for (int i = 0; i < 20 && !(g0 && g1); i++) begin
            @(posedge clk); #1;
            if (first && (r0_gnt || r1_gnt)) begin
                check("tie_after_reset", 32'({r1_gnt, r0_gnt}), 32'd1);
                first = 1'b0;
            end
            if (r0_gnt) begin g0 = 1'b1; set_req(0, 1'b0, ta); end
            if (r1_gnt) begin g1 = 1'b1; set_req(1, 1'b0, tb); end
        end
        check("tie_both_granted", 32'({g1, g0}), 32'd3);
        repeat (6) begin @(posedge clk); #1; end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
